// File: rtl/video_pkg.sv
// Shared video constants and colour type for the sprite compositing path.
package video_pkg;
  localparam int COLOR_BITS        = 4;
  localparam int TRANSPARENT_INDEX = 0;
  localparam int SPRITE_ADDR_BITS  = 8;
  localparam int PIPE_LATENCY      = 2;
  localparam int PAL_IDX_BITS      = 4;
  localparam int PAL_ENTRIES       = 1 << PAL_IDX_BITS;

  typedef struct packed {
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
  } rgb_t;
endpackage

// File: rtl/sprite_palette.sv
// 16-entry colour register file: one synchronous write port, one combinational read port.
module sprite_palette
  import video_pkg::*;
#(
  parameter int W = 3 * COLOR_BITS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    we,
  input  logic [PAL_IDX_BITS-1:0] wr_idx,
  input  logic [W-1:0]            wr_data,
  input  logic [PAL_IDX_BITS-1:0] rd_idx,
  output logic [W-1:0]            rd_data
);
  logic [PAL_ENTRIES-1:0][W-1:0] mem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem <= '0;
    else if (we)  mem[wr_idx] <= wr_data;
  end

  // Read sees the pre-edge contents, so a same-cycle write is not forwarded.
  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite-over-playfield compositor with palette lookup and sticky collision flag.
module sprite_compositor #(
  parameter int COLOR_BITS        = video_pkg::COLOR_BITS,
  parameter int TRANSPARENT_INDEX = video_pkg::TRANSPARENT_INDEX
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   sprite_active,
  input  logic [video_pkg::SPRITE_ADDR_BITS-1:0] sprite_address,
  input  logic                                   in_visible,
  input  logic                                   in_hsync,
  input  logic                                   in_vsync,
  input  logic [3*COLOR_BITS-1:0]                bg_color,
  input  logic                                   bg_opaque,
  output logic [video_pkg::SPRITE_ADDR_BITS-1:0] sprite_rom_addr,
  input  logic [video_pkg::PAL_IDX_BITS-1:0]     sprite_rom_data,
  input  logic                                   pal_we,
  input  logic [video_pkg::PAL_IDX_BITS-1:0]     pal_index,
  input  logic [3*COLOR_BITS-1:0]                pal_data,
  input  logic                                   collision_clear,
  output logic                                   collision,
  output logic [3*COLOR_BITS-1:0]                vga_color,
  output logic                                   vga_hsync,
  output logic                                   vga_vsync
);
  localparam int CW = 3 * COLOR_BITS;
  localparam logic [video_pkg::PAL_IDX_BITS-1:0] TRANSP = video_pkg::PAL_IDX_BITS'(TRANSPARENT_INDEX);

  logic          act_s1, vis_s1, hs_s1, vs_s1, bgo_s1;
  logic [CW-1:0] bg_s1;
  logic          opaque_hit, coll_set;
  logic [CW-1:0] pal_rd, color_d;

  // Stage 0: the external ROM registers the address, so its data lines up with stage 1.
  assign sprite_rom_addr = sprite_address;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_s1 <= 1'b0;
      vis_s1 <= 1'b0;
      hs_s1  <= 1'b1;
      vs_s1  <= 1'b1;
      bgo_s1 <= 1'b0;
      bg_s1  <= '0;
    end else begin
      act_s1 <= sprite_active;
      vis_s1 <= in_visible;
      hs_s1  <= in_hsync;
      vs_s1  <= in_vsync;
      bgo_s1 <= bg_opaque;
      bg_s1  <= bg_color;
    end
  end

  assign opaque_hit = act_s1 && (sprite_rom_data != TRANSP);
  assign coll_set   = opaque_hit && bgo_s1 && vis_s1;

  sprite_palette #(.W(CW)) u_pal (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (pal_we),
    .wr_idx  (pal_index),
    .wr_data (pal_data),
    .rd_idx  (sprite_rom_data),
    .rd_data (pal_rd)
  );

  always_comb begin
    color_d = '0;
    if (vis_s1) color_d = opaque_hit ? pal_rd : bg_s1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_color <= '0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      collision <= 1'b0;
    end else begin
      vga_color <= color_d;
      vga_hsync <= hs_s1;
      vga_vsync <= vs_s1;
      // A new hit outranks a coincident clear.
      collision <= coll_set || (collision && !collision_clear);
    end
  end
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed checks of the sprite compositor: reset, transparency, alignment, collision, blanking, palette hazard.
module tb_sprite_compositor;
  import video_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sprite_active = 1'b0;
  logic [7:0]  sprite_address = '0;
  logic        in_visible = 1'b0, in_hsync = 1'b1, in_vsync = 1'b1;
  logic [11:0] bg_color = '0;
  logic        bg_opaque = 1'b0;
  logic [7:0]  sprite_rom_addr;
  logic [3:0]  sprite_rom_data = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_index = '0;
  logic [11:0] pal_data = '0;
  logic        collision_clear = 1'b0;
  logic        collision;
  logic [11:0] vga_color;
  logic        vga_hsync, vga_vsync;

  logic [3:0]  rom [256];
  int checks = 0;
  int failures = 0;

  sprite_compositor dut (
    .clk(clk), .reset_n(reset_n),
    .sprite_active(sprite_active), .sprite_address(sprite_address),
    .in_visible(in_visible), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .bg_color(bg_color), .bg_opaque(bg_opaque),
    .sprite_rom_addr(sprite_rom_addr), .sprite_rom_data(sprite_rom_data),
    .pal_we(pal_we), .pal_index(pal_index), .pal_data(pal_data),
    .collision_clear(collision_clear), .collision(collision),
    .vga_color(vga_color), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
  );

  always #5 clk = ~clk;

  // Synchronous sprite ROM model: one cycle of read latency.
  always @(posedge clk) sprite_rom_data <= rom[sprite_rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pix(input logic act, input logic [7:0] addr, input logic vis,
                     input logic [11:0] bg, input logic bgo);
    sprite_active  = act;
    sprite_address = addr;
    in_visible     = vis;
    bg_color       = bg;
    bg_opaque      = bgo;
  endtask

  task automatic pal_write(input logic [3:0] idx, input logic [11:0] data);
    pal_we = 1'b1; pal_index = idx; pal_data = data;
    tick();
    pal_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 4'd0;
    rom[8'h12] = 4'd5;
    rom[8'h13] = 4'd0;
    rom[8'h30] = 4'd3;

    // Reset held with busy inputs
    pix(1'b1, 8'h12, 1'b1, 12'h00F, 1'b1);
    in_hsync = 1'b0; in_vsync = 1'b0;
    repeat (3) tick();
    chk("rst_color", 32'(vga_color), 32'h000);
    chk("rst_hsync", 32'(vga_hsync), 32'h1);
    chk("rst_vsync", 32'(vga_vsync), 32'h1);
    chk("rst_coll",  32'(collision), 32'h0);

    pix(1'b0, 8'h00, 1'b0, 12'h000, 1'b0);
    in_hsync = 1'b1; in_vsync = 1'b1;
    reset_n = 1'b1;
    tick();
    pal_write(4'd5, 12'hF00);
    pal_write(4'd3, 12'hFFF);

    // Transparency: opaque index then transparent index, back to back
    pix(1'b1, 8'h12, 1'b1, 12'h00F, 1'b0);
    tick();
    pix(1'b1, 8'h13, 1'b1, 12'h00F, 1'b0);
    tick();
    chk("opaque_pix", 32'(vga_color), 32'hF00);
    pix(1'b0, 8'h00, 1'b1, 12'h000, 1'b0);
    tick();
    chk("transp_pix", 32'(vga_color), 32'h00F);

    // Alignment of syncs with colour
    pix(1'b0, 8'h00, 1'b1, 12'h0A0, 1'b0);
    in_hsync = 1'b0; in_vsync = 1'b0;
    tick();
    pix(1'b0, 8'h00, 1'b1, 12'h000, 1'b0);
    in_hsync = 1'b1; in_vsync = 1'b1;
    chk("hs_lat1", 32'(vga_hsync), 32'h1);
    tick();
    chk("hs_lat2",  32'(vga_hsync), 32'h0);
    chk("vs_lat2",  32'(vga_vsync), 32'h0);
    chk("hs_color", 32'(vga_color), 32'h0A0);
    tick();
    chk("hs_back", 32'(vga_hsync), 32'h1);

    // Collision set, sticky, clear vs. hit
    pix(1'b1, 8'h12, 1'b1, 12'h00F, 1'b1);
    tick();
    chk("coll_1edge", 32'(collision), 32'h0);
    tick();
    chk("coll_2edge", 32'(collision), 32'h1);
    collision_clear = 1'b1;
    tick();
    collision_clear = 1'b0;
    chk("clear_vs_hit", 32'(collision), 32'h1);
    pix(1'b0, 8'h00, 1'b1, 12'h000, 1'b0);
    tick();
    chk("coll_sticky", 32'(collision), 32'h1);
    collision_clear = 1'b1;
    tick();
    collision_clear = 1'b0;
    chk("coll_clear", 32'(collision), 32'h0);

    // Blanking: opaque sprite over opaque playfield, not visible
    pix(1'b1, 8'h12, 1'b0, 12'h00F, 1'b1);
    tick();
    tick();
    chk("blank_color", 32'(vga_color), 32'h000);
    chk("blank_coll",  32'(collision), 32'h0);
    tick();
    chk("blank_coll2", 32'(collision), 32'h0);

    // Palette hazard: write entry 3 while stage 2 reads it
    pix(1'b1, 8'h30, 1'b1, 12'h00F, 1'b0);
    tick();
    pal_we = 1'b1; pal_index = 4'd3; pal_data = 12'h0F0;
    tick();
    pal_we = 1'b0;
    chk("haz_old", 32'(vga_color), 32'hFFF);
    tick();
    chk("haz_new", 32'(vga_color), 32'h0F0);

    // Asynchronous reset mid-frame
    in_hsync = 1'b0; in_vsync = 1'b0;
    tick();
    tick();
    chk("pre_arst_hs", 32'(vga_hsync), 32'h0);
    reset_n = 1'b0;
    #2;
    chk("arst_color", 32'(vga_color), 32'h000);
    chk("arst_hsync", 32'(vga_hsync), 32'h1);
    chk("arst_vsync", 32'(vga_vsync), 32'h1);
    tick();
    tick();
    in_hsync = 1'b1; in_vsync = 1'b1;
    pix(1'b1, 8'h12, 1'b1, 12'h00F, 1'b0);
    reset_n = 1'b1;
    tick();
    pix(1'b0, 8'h00, 1'b1, 12'h0C0, 1'b0);
    tick();
    chk("pal_cleared", 32'(vga_color), 32'h000);
    tick();
    chk("post_rst_bg", 32'(vga_color), 32'h0C0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
